cache_rd_arbiter: RTL and testbench

Arbitrates the icache and dcache refill/uncached read requests (rd_req/rd_rdy/ret_* style) onto one shared AXI read channel (AR/R).
Allows one outstanding read per requester, distinguished by ARID, and routes R beats back by RID.
Blocks dcache reads that hit a line still pending in the write path (RAW hazard).

---
 rtl/cache_rd_arbiter_if.sv | 43 ++++
 rtl/cache_rd_arbiter.sv | 123 ++++++++++++
 tb/tb_cache_rd_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_rd_arbiter_if.sv
// Signal bundle between the cache read ports, the write-buffer hazard inputs and the AXI AR/R channel.
// The master modport is the arbiter's side; the slave modport is the caches plus the AXI slave.
interface cache_rd_arbiter_if;
    logic        i_rd_req;
    logic [2:0]  i_rd_type;
    logic [31:0] i_rd_addr;
    logic        i_rd_rdy;
    logic        i_ret_valid;
    logic        d_rd_req;
    logic [2:0]  d_rd_type;
    logic [31:0] d_rd_addr;
    logic        d_rd_rdy;
    logic        d_ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
    logic        wb_busy;
    logic [31:0] wb_addr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  i_rd_req, i_rd_type, i_rd_addr, d_rd_req, d_rd_type, d_rd_addr,
        input  wb_busy, wb_addr, arready, rid, rdata, rlast, rvalid,
        output i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid, ret_last, ret_data,
        output arid, araddr, arlen, arsize, arvalid, rready
    );

    modport slave (
        output i_rd_req, i_rd_type, i_rd_addr, d_rd_req, d_rd_type, d_rd_addr,
        output wb_busy, wb_addr, arready, rid, rdata, rlast, rvalid,
        input  i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid, ret_last, ret_data,
        input  arid, araddr, arlen, arsize, arvalid, rready
    );
endinterface

// File: rtl/cache_rd_arbiter.sv
// Arbitrates icache/dcache reads onto one AXI read channel, one outstanding read per requester,
// with R beats routed back by RID and dcache reads held off while a same-line write is pending.
module cache_rd_arbiter #(
    parameter logic [3:0] I_ID = 4'd0,
    parameter logic [3:0] D_ID = 4'd1
) (
    input logic                clk,
    input logic                rst,
    cache_rd_arbiter_if.master bus
);
    typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_e;

    ar_state_e   state_q, state_d;
    logic        i_flag_q, d_flag_q, prio_d_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q;
    logic        hazard, i_elig, d_elig, i_grant, d_grant;
    logic        i_last, d_last, rready;
    logic [2:0]  sel_type;
    logic [31:0] sel_addr;

    function automatic logic [7:0] len_of(input logic [2:0] t);
        return (t == 3'b100) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] t);
        case (t)
            3'b000:  return 3'd0;
            3'b001:  return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [31:0] addr_of(input logic [2:0] t, input logic [31:0] a);
        return (t == 3'b100) ? {a[31:4], 4'b0} : a;
    endfunction

    assign hazard = bus.wb_busy && (bus.wb_addr[31:4] == bus.d_rd_addr[31:4]);
    assign i_elig = bus.i_rd_req && !i_flag_q;
    assign d_elig = bus.d_rd_req && !d_flag_q && !hazard;

    assign rready = ~rst;
    assign i_last = rready & bus.rvalid & bus.rlast & (bus.rid == I_ID) & i_flag_q;
    assign d_last = rready & bus.rvalid & bus.rlast & (bus.rid == D_ID) & d_flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            AR_IDLE: if (i_grant || d_grant) state_d = AR_SEND;
            AR_SEND: if (bus.arready) state_d = AR_IDLE;
            default: state_d = AR_IDLE;
        endcase
    end

    // prio_d_q set means the dcache wins a tie.
    always_comb begin
        i_grant     = 1'b0;
        d_grant     = 1'b0;
        bus.arvalid = 1'b0;
        if (!rst) begin
            if (state_q == AR_IDLE) begin
                d_grant = d_elig && (!i_elig || prio_d_q);
                i_grant = i_elig && !d_grant;
            end
            bus.arvalid = (state_q == AR_SEND);
        end
        bus.i_rd_rdy = i_grant;
        bus.d_rd_rdy = d_grant;
    end

    assign sel_type = d_grant ? bus.d_rd_type : bus.i_rd_type;
    assign sel_addr = d_grant ? bus.d_rd_addr : bus.i_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            arid_q   <= 4'd0;
            araddr_q <= 32'd0;
            arlen_q  <= 8'd0;
            arsize_q <= 3'd0;
            i_flag_q <= 1'b0;
            d_flag_q <= 1'b0;
            prio_d_q <= 1'b1;
        end else begin
            if (i_grant || d_grant) begin
                arid_q   <= d_grant ? D_ID : I_ID;
                araddr_q <= addr_of(sel_type, sel_addr);
                arlen_q  <= len_of(sel_type);
                arsize_q <= size_of(sel_type);
                prio_d_q <= i_grant;
            end
            if (i_grant) begin
                i_flag_q <= 1'b1;
            end else if (i_last) begin
                i_flag_q <= 1'b0;
            end
            if (d_grant) begin
                d_flag_q <= 1'b1;
            end else if (d_last) begin
                d_flag_q <= 1'b0;
            end
        end
    end

    assign bus.arid        = arid_q;
    assign bus.araddr      = araddr_q;
    assign bus.arlen       = arlen_q;
    assign bus.arsize      = arsize_q;
    assign bus.rready      = rready;
    assign bus.ret_data    = bus.rdata;
    assign bus.ret_last    = bus.rlast;
    assign bus.i_ret_valid = rready & bus.rvalid & (bus.rid == I_ID) & i_flag_q;
    assign bus.d_ret_valid = rready & bus.rvalid & (bus.rid == D_ID) & d_flag_q;
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: directed scenarios plus a randomized run against a transaction-level
// model of grants, AR fields, outstanding reads and R routing.
module tb_cache_rd_arbiter;
    localparam logic [3:0] I_ID = 4'd0;
    localparam logic [3:0] D_ID = 4'd1;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    cache_rd_arbiter_if bus ();

    cache_rd_arbiter #(.I_ID(I_ID), .D_ID(D_ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] exp_len(input logic [2:0] t);
        int beats;
        beats = (t == 3'd4) ? 4 : 1;
        return 8'(beats - 1);
    endfunction

    function automatic logic [2:0] exp_size(input logic [2:0] t);
        int bytes;
        int sz;
        bytes = (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
        sz = 0;
        while ((1 << sz) < bytes) sz++;
        return 3'(sz);
    endfunction

    function automatic logic [31:0] exp_addr(input logic [2:0] t, input logic [31:0] a);
        return (t == 3'd4) ? (a & ~32'hF) : a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;
        bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0;
        bus.wb_busy = 0; bus.wb_addr = 0; bus.arready = 0;
        bus.rid = 0; bus.rdata = 0; bus.rlast = 0; bus.rvalid = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        bus.i_rd_req = 1; bus.d_rd_req = 1; bus.rvalid = 1; bus.rid = I_ID; bus.rlast = 1;
        tick(); tick(); settle();
        n_cmp++;
        if ({bus.i_rd_rdy, bus.d_rd_rdy, bus.i_ret_valid, bus.d_ret_valid, bus.arvalid,
             bus.rready} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.i_rd_rdy, bus.d_rd_rdy,
                     bus.i_ret_valid, bus.d_ret_valid, bus.arvalid, bus.rready});
        end
        n_cmp++;
        if ({bus.arid, bus.araddr, bus.arlen, bus.arsize} !== 47'd0) begin
            n_err++;
            $display("FAIL reset_ar: got %h want 0", {bus.arid, bus.araddr, bus.arlen, bus.arsize});
        end
        tick();
        idle_inputs();
        rst = 0;
        settle();
        n_cmp++;
        if ({bus.rready, bus.arvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_release: got rready/arvalid %b want 10", {bus.rready, bus.arvalid});
        end
    endtask

    task automatic test_icache_line();
        logic [31:0] data [4];
        reset_dut();
        bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h1c00_0014;
        settle();
        n_cmp++;
        if ({bus.i_rd_rdy, bus.d_rd_rdy} !== 2'b10) begin
            n_err++;
            $display("FAIL line_rdy: got %b want 10", {bus.i_rd_rdy, bus.d_rd_rdy});
        end
        tick();
        bus.i_rd_req = 0; bus.arready = 1;
        settle();
        n_cmp++;
        if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize} !==
            {1'b1, I_ID, 32'h1c00_0010, 8'd3, 3'd2}) begin
            n_err++;
            $display("FAIL line_ar: got %h want %h", {bus.arvalid, bus.arid, bus.araddr,
                     bus.arlen, bus.arsize}, {1'b1, I_ID, 32'h1c00_0010, 8'd3, 3'd2});
        end
        tick();
        bus.arready = 0;
        settle();
        n_cmp++;
        if (bus.arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL line_ar_drop: got arvalid %b want 0", bus.arvalid);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            data[b] = $urandom;
            bus.rvalid = 1; bus.rid = I_ID; bus.rdata = data[b]; bus.rlast = (b == 3);
            settle();
            n_cmp++;
            if ({bus.i_ret_valid, bus.d_ret_valid, bus.ret_last, bus.ret_data} !==
                {1'b1, 1'b0, b == 3, data[b]}) begin
                n_err++;
                $display("FAIL line_beat%0d: got %h want %h", b, {bus.i_ret_valid,
                         bus.d_ret_valid, bus.ret_last, bus.ret_data}, {1'b1, 1'b0, b == 3, data[b]});
            end
        end
        tick();
        bus.rlast = 0;
        settle();
        n_cmp++;
        if (bus.i_ret_valid !== 1'b0) begin
            n_err++;
            $display("FAIL line_after_last: got i_ret_valid %b want 0", bus.i_ret_valid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        bit          pend [2];
        bit          prev_i, prev_d;
        logic [2:0]  seq;
        int          ng;
        logic [3:0]  sent_id;
        reset_dut();
        bus.i_rd_req = 1; bus.i_rd_type = 3'b010; bus.i_rd_addr = 32'h100;
        bus.d_rd_req = 1; bus.d_rd_type = 3'b010; bus.d_rd_addr = 32'h200;
        bus.arready = 1;
        pend = '{0, 0}; prev_i = 0; prev_d = 0; seq = 0; ng = 0; sent_id = 0;
        for (int c = 0; c < 12 && ng < 3; c++) begin
            bus.rvalid = 0; bus.rlast = 0;
            if (pend[1]) begin
                bus.rvalid = 1; bus.rid = D_ID; bus.rlast = 1;
            end else if (pend[0]) begin
                bus.rvalid = 1; bus.rid = I_ID; bus.rlast = 1;
            end
            settle();
            n_cmp++;
            if ((bus.i_rd_rdy && (prev_i || bus.d_rd_rdy)) || (bus.d_rd_rdy && prev_d)) begin
                n_err++;
                $display("FAIL rr_rdy_pulse: cycle %0d i_rdy %b d_rdy %b prev %b%b want single pulses",
                         c, bus.i_rd_rdy, bus.d_rd_rdy, prev_i, prev_d);
            end
            if (bus.rvalid) pend[bus.rid == D_ID] = 0;
            if (bus.arvalid && bus.arready) pend[sent_id == D_ID] = 1;
            if (bus.d_rd_rdy || bus.i_rd_rdy) begin
                seq = {seq[1:0], bus.d_rd_rdy};
                ng++;
                sent_id = bus.d_rd_rdy ? D_ID : I_ID;
            end
            prev_i = bus.i_rd_rdy; prev_d = bus.d_rd_rdy;
            tick();
        end
        n_cmp++;
        if (ng != 3 || seq !== 3'b101) begin
            n_err++;
            $display("FAIL rr_order: got %0d grants seq %b (1=dcache) want 3 grants seq 101", ng, seq);
        end
        idle_inputs();
    endtask

    task automatic test_hazard();
        reset_dut();
        bus.wb_busy = 1; bus.wb_addr = 32'h0000_1230;
        bus.d_rd_req = 1; bus.d_rd_type = 3'b010; bus.d_rd_addr = 32'h0000_1238;
        bus.i_rd_req = 1; bus.i_rd_type = 3'b010; bus.i_rd_addr = 32'h0000_0400;
        settle();
        n_cmp++;
        if ({bus.i_rd_rdy, bus.d_rd_rdy} !== 2'b10) begin
            n_err++;
            $display("FAIL hz_icache_grant: got %b want 10", {bus.i_rd_rdy, bus.d_rd_rdy});
        end
        tick();
        bus.i_rd_req = 0; bus.arready = 1;
        settle();
        n_cmp++;
        if ({bus.arvalid, bus.arid, bus.araddr, bus.d_rd_rdy} !== {1'b1, I_ID, 32'h400, 1'b0}) begin
            n_err++;
            $display("FAIL hz_icache_ar: got %h want %h", {bus.arvalid, bus.arid, bus.araddr,
                     bus.d_rd_rdy}, {1'b1, I_ID, 32'h400, 1'b0});
        end
        tick();
        bus.arready = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_cmp++;
            if (bus.d_rd_rdy !== 1'b0) begin
                n_err++;
                $display("FAIL hz_stall: cycle %0d got d_rd_rdy %b want 0", c, bus.d_rd_rdy);
            end
            tick();
        end
        bus.wb_busy = 0;
        settle();
        n_cmp++;
        if (bus.d_rd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL hz_release: got d_rd_rdy %b want 1", bus.d_rd_rdy);
        end
        tick();
        bus.d_rd_req = 0;
        settle();
        n_cmp++;
        if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize} !==
            {1'b1, D_ID, 32'h0000_1238, 8'd0, 3'd2}) begin
            n_err++;
            $display("FAIL hz_dcache_ar: got %h want %h", {bus.arvalid, bus.arid, bus.araddr,
                     bus.arlen, bus.arsize}, {1'b1, D_ID, 32'h0000_1238, 8'd0, 3'd2});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_interleave();
        logic [3:0]  ids [8];
        int          cnt [2];
        bit          is_d, lst;
        logic [31:0] dat;
        reset_dut();
        ids = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
        cnt = '{0, 0};
        bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h2000;
        bus.d_rd_req = 1; bus.d_rd_type = 3'b100; bus.d_rd_addr = 32'h3000;
        bus.arready = 1;
        settle();
        n_cmp++;
        if ({bus.i_rd_rdy, bus.d_rd_rdy} !== 2'b01) begin
            n_err++;
            $display("FAIL il_first: got %b want 01", {bus.i_rd_rdy, bus.d_rd_rdy});
        end
        tick();
        bus.d_rd_req = 0;
        tick();
        settle();
        n_cmp++;
        if ({bus.i_rd_rdy, bus.d_rd_rdy} !== 2'b10) begin
            n_err++;
            $display("FAIL il_second: got %b want 10", {bus.i_rd_rdy, bus.d_rd_rdy});
        end
        tick();
        bus.i_rd_req = 0;
        tick();
        bus.arready = 0;
        bus.i_rd_type = 3'b010; bus.d_rd_type = 3'b010;
        for (int k = 0; k < 8; k++) begin
            is_d = (ids[k] == D_ID);
            cnt[is_d]++;
            lst = (cnt[is_d] == 4);
            dat = $urandom;
            bus.rvalid = 1; bus.rid = ids[k]; bus.rdata = dat; bus.rlast = lst;
            bus.i_rd_req = (k >= 6); bus.d_rd_req = (k == 7);
            settle();
            n_cmp++;
            if ({bus.i_ret_valid, bus.d_ret_valid, bus.ret_last, bus.ret_data} !==
                {!is_d, is_d, lst, dat}) begin
                n_err++;
                $display("FAIL il_beat%0d: got %h want %h", k, {bus.i_ret_valid, bus.d_ret_valid,
                         bus.ret_last, bus.ret_data}, {!is_d, is_d, lst, dat});
            end
            if (k >= 6) begin
                n_cmp++;
                if ({bus.i_rd_rdy, bus.d_rd_rdy} !== {1'b0, k == 7}) begin
                    n_err++;
                    $display("FAIL il_flag%0d: got rdy %b want %b", k, {bus.i_rd_rdy, bus.d_rd_rdy},
                             {1'b0, k == 7});
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_ar_stall();
        reset_dut();
        bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h4000_0024;
        settle();
        tick();
        bus.i_rd_req = 0;
        bus.d_rd_req = 1; bus.d_rd_type = 3'b001; bus.d_rd_addr = 32'h5000_0002;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_cmp++;
            if ({bus.arvalid, bus.arid, bus.araddr, bus.i_rd_rdy, bus.d_rd_rdy} !==
                {1'b1, I_ID, 32'h4000_0020, 2'b00}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got %h want %h", c, {bus.arvalid, bus.arid,
                         bus.araddr, bus.i_rd_rdy, bus.d_rd_rdy}, {1'b1, I_ID, 32'h4000_0020, 2'b00});
            end
            tick();
        end
        bus.arready = 1;
        settle();
        n_cmp++;
        if ({bus.arvalid, bus.d_rd_rdy} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_handshake: got %b want 10", {bus.arvalid, bus.d_rd_rdy});
        end
        tick();
        bus.arready = 0;
        settle();
        n_cmp++;
        if ({bus.arvalid, bus.d_rd_rdy} !== 2'b01) begin
            n_err++;
            $display("FAIL stall_next_grant: got %b want 01", {bus.arvalid, bus.d_rd_rdy});
        end
        tick();
        bus.d_rd_req = 0;
        settle();
        n_cmp++;
        if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize} !==
            {1'b1, D_ID, 32'h5000_0002, 8'd0, 3'd1}) begin
            n_err++;
            $display("FAIL stall_second_ar: got %h want %h", {bus.arvalid, bus.arid, bus.araddr,
                     bus.arlen, bus.arsize}, {1'b1, D_ID, 32'h5000_0002, 8'd0, 3'd1});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        bus.d_rd_req = 1; bus.d_rd_type = 3'b010; bus.d_rd_addr = 32'h6000_0000;
        tick();
        bus.d_rd_req = 0;
        settle();
        n_cmp++;
        if (bus.arvalid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_send: got arvalid %b want 1", bus.arvalid);
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        bus.rvalid = 1; bus.rid = D_ID; bus.rlast = 1; bus.rdata = 32'hdead_beef;
        settle();
        n_cmp++;
        if ({bus.arvalid, bus.i_ret_valid, bus.d_ret_valid, bus.rready} !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_stray: got %b want 0001", {bus.arvalid, bus.i_ret_valid,
                     bus.d_ret_valid, bus.rready});
        end
        tick();
        bus.rvalid = 0; bus.rlast = 0; bus.d_rd_req = 1;
        settle();
        n_cmp++;
        if (bus.d_rd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_flag_cleared: got d_rd_rdy %b want 1", bus.d_rd_rdy);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        bit          m_flag [2];
        bit          r_pend [2];
        int          r_left [2];
        bit          m_last_d, m_send, hz, ie, de, ex_i, ex_d, drop_i, drop_d, bi, bd;
        logic [3:0]  m_id;
        logic [31:0] m_addr;
        logic [7:0]  m_len;
        logic [2:0]  m_size, t;
        int          r;
        reset_dut();
        m_flag = '{0, 0}; r_pend = '{0, 0}; r_left = '{0, 0};
        m_last_d = 0; m_send = 0; m_id = 0; m_addr = 0; m_len = 0; m_size = 0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.i_rd_req && $urandom_range(0, 2) == 0) begin
                bus.i_rd_req = 1; bus.i_rd_type = 3'($urandom_range(0, 7)); bus.i_rd_addr = $urandom;
            end
            if (!bus.d_rd_req && $urandom_range(0, 2) == 0) begin
                bus.d_rd_req = 1; bus.d_rd_type = 3'($urandom_range(0, 7));
                bus.d_rd_addr = $urandom & 32'h3f;
            end
            bus.wb_busy = ($urandom_range(0, 3) == 0);
            bus.wb_addr = $urandom & 32'h3f;
            bus.arready = 1'($urandom_range(0, 1));
            bus.rvalid = 0; bus.rlast = 0; bus.rid = 0; bus.rdata = $urandom;
            r = $urandom_range(0, 5);
            if (r == 0) begin
                bus.rvalid = 1; bus.rid = 4'($urandom_range(2, 15)); bus.rlast = 1'($urandom);
            end else if (r <= 2 && r_pend[0]) begin
                bus.rvalid = 1; bus.rid = I_ID; bus.rlast = (r_left[0] == 1);
            end else if (r <= 4 && r_pend[1]) begin
                bus.rvalid = 1; bus.rid = D_ID; bus.rlast = (r_left[1] == 1);
            end
            settle();
            hz = bus.wb_busy && ((bus.wb_addr >> 4) == (bus.d_rd_addr >> 4));
            ie = bus.i_rd_req && !m_flag[0];
            de = bus.d_rd_req && !m_flag[1] && !hz;
            ex_d = !m_send && de && (!ie || !m_last_d);
            ex_i = !m_send && ie && !ex_d;
            bi = bus.rvalid && bus.rid == I_ID && m_flag[0];
            bd = bus.rvalid && bus.rid == D_ID && m_flag[1];
            n_cmp++;
            if ({bus.i_rd_rdy, bus.d_rd_rdy} !== {ex_i, ex_d}) begin
                n_err++;
                $display("FAIL rnd_rdy: cycle %0d got %b want %b", c, {bus.i_rd_rdy, bus.d_rd_rdy},
                         {ex_i, ex_d});
            end
            n_cmp++;
            if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize} !==
                {m_send, m_id, m_addr, m_len, m_size}) begin
                n_err++;
                $display("FAIL rnd_ar: cycle %0d got %h want %h", c, {bus.arvalid, bus.arid,
                         bus.araddr, bus.arlen, bus.arsize}, {m_send, m_id, m_addr, m_len, m_size});
            end
            n_cmp++;
            if ({bus.i_ret_valid, bus.d_ret_valid, bus.ret_last, bus.ret_data, bus.rready} !==
                {bi, bd, bus.rlast, bus.rdata, 1'b1}) begin
                n_err++;
                $display("FAIL rnd_ret: cycle %0d got %h want %h", c, {bus.i_ret_valid,
                         bus.d_ret_valid, bus.ret_last, bus.ret_data, bus.rready},
                         {bi, bd, bus.rlast, bus.rdata, 1'b1});
            end
            if (m_send && bus.arready) begin
                m_send = 0;
                r_pend[m_id == D_ID] = 1;
                r_left[m_id == D_ID] = int'(m_len) + 1;
            end
            if ((bi || bd) && bus.rlast) m_flag[bd] = 0;
            if (bi || bd) begin
                r_left[bd]--;
                if (r_left[bd] == 0) r_pend[bd] = 0;
            end
            drop_i = ex_i; drop_d = ex_d;
            if (ex_i || ex_d) begin
                t = ex_d ? bus.d_rd_type : bus.i_rd_type;
                m_addr = exp_addr(t, ex_d ? bus.d_rd_addr : bus.i_rd_addr);
                m_len = exp_len(t); m_size = exp_size(t);
                m_id = ex_d ? D_ID : I_ID;
                m_send = 1; m_flag[ex_d] = 1; m_last_d = ex_d;
            end
            tick();
            if (drop_i) bus.i_rd_req = 0;
            if (drop_d) bus.d_rd_req = 0;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_icache_line();
        test_round_robin();
        test_hazard();
        test_interleave();
        test_ar_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
